// File: rtl/dmac_pkg.sv
// dmac_pkg: shared constants for the DMAC control/status register file.
//   - CSR address map (CTRL, STATUS, first CFG register)
//   - bit positions inside CTRL and STATUS
package dmac_pkg;

  // Register addresses
  localparam int unsigned CSR_CTRL     = 0;
  localparam int unsigned CSR_STATUS   = 1;
  localparam int unsigned CSR_CFG_BASE = 2;

  // CTRL bit positions
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IE      = 1;

  // STATUS bit positions
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_ERR       = 2;

endpackage

// File: rtl/dmac_csr_status.sv
// dmac_csr_status: DONE/ERR status flags and the registered interrupt.
//
// Build option: DMAC_CSR_ERR_EN
//   defined   -> ERR flag stored; irq_o = (DONE | ERR) & IE
//   undefined -> ERR reads 0, not stored; irq_o = DONE & IE
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous, active-high reset
//   done_i      engine completion pulse (sets DONE)
//   clr_done_i  write-1-to-clear request for DONE
//   set_err_i   rejected START/CFG write (only with DMAC_CSR_ERR_EN)
//   clr_err_i   write-1-to-clear request for ERR (only with DMAC_CSR_ERR_EN)
//   ie_d_i      next-state value of the CTRL.IE bit
//   done_o      DONE flag
//   err_o       ERR flag (constant 0 without DMAC_CSR_ERR_EN)
//   irq_o       level interrupt, registered
module dmac_csr_status (
  input  logic clk_i,
  input  logic reset_i,
  input  logic done_i,
  input  logic clr_done_i,
`ifdef DMAC_CSR_ERR_EN
  input  logic set_err_i,
  input  logic clr_err_i,
`endif
  input  logic ie_d_i,
  output logic done_o,
  output logic err_o,
  output logic irq_o
);

  logic done_q, done_d;
  logic irq_q, irq_d;

  // Set is applied after clear so a coincident done_i wins.
  always_comb begin
    done_d = done_q;
    if (clr_done_i) done_d = 1'b0;
    if (done_i)     done_d = 1'b1;
  end

`ifdef DMAC_CSR_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (clr_err_i) err_d = 1'b0;
    if (set_err_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
  assign irq_d = (done_d | err_d) & ie_d_i;
`else
  assign err_o = 1'b0;
  assign irq_d = done_d & ie_d_i;
`endif

  // irq is computed from next-state flags so it lines up with DONE/IE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      irq_q  <= irq_d;
    end
  end

  assign done_o = done_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/dmac_csr_file.sv
// dmac_csr_file: CPU-facing control/status register file for the DMAC.
//
// Build option: DMAC_CSR_ERR_EN enables the STATUS.ERR flag (rejected
// START and CFG writes set it; it also contributes to irq_o).
//
// Register map:
//   0 CTRL   : bit0 START (write-only, self-clearing), bit1 IE
//   1 STATUS : bit0 BUSY (live busy_i), bit1 DONE (W1C), bit2 ERR (W1C)
//   2..NUM_REGS-1 CFG : plain R/W, locked while the engine is busy
//   >= NUM_REGS       : writes ignored, reads return 0
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   we/wAddr/wData  register write port
//   re/rAddr        register read request
//   rData/rValid    registered read data and one-cycle valid strobe
//   start_o         one-cycle start pulse to the engine
//   busy_i/done_i   engine busy level and completion pulse
//   irq_o           level interrupt
//   cfg_o           CFG registers 2..NUM_REGS-1, reg 2 in the LSBs
import dmac_pkg::*;

module dmac_csr_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              wAddr,
  input  logic [DATA_W-1:0]              wData,
  input  logic                           re,
  input  logic [ADDR_W-1:0]              rAddr,
  output logic [DATA_W-1:0]              rData,
  output logic                           rValid,
  output logic                           start_o,
  input  logic                           busy_i,
  input  logic                           done_i,
  output logic                           irq_o,
  output logic [(NUM_REGS-2)*DATA_W-1:0] cfg_o
);

  localparam int unsigned NCFG = NUM_REGS - 2;

  logic              ie_q, ie_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] cfg_q [NCFG];
  logic [DATA_W-1:0] cfg_d [NCFG];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;

  logic busy_eff;
  logic wr_ctrl, wr_status, wr_cfg_hit;
  logic done_flag, err_flag;

  // A pending start pulse counts as busy so a back-to-back START is rejected.
  assign busy_eff  = busy_i | start_q;
  assign wr_ctrl   = we && (wAddr == ADDR_W'(CSR_CTRL));
  assign wr_status = we && (wAddr == ADDR_W'(CSR_STATUS));

  always_comb begin
    wr_cfg_hit = 1'b0;
    for (int unsigned i = 0; i < NCFG; i++) begin
      if (wAddr == ADDR_W'(i + CSR_CFG_BASE)) wr_cfg_hit = 1'b1;
    end
  end

  assign ie_d    = wr_ctrl ? wData[CTRL_IE] : ie_q;
  assign start_d = wr_ctrl && wData[CTRL_START] && !busy_eff;

  always_comb begin
    cfg_d = cfg_q;
    if (we && wr_cfg_hit && !busy_eff) begin
      for (int unsigned i = 0; i < NCFG; i++) begin
        if (wAddr == ADDR_W'(i + CSR_CFG_BASE)) cfg_d[i] = wData;
      end
    end
  end

`ifdef DMAC_CSR_ERR_EN
  logic set_err;
  assign set_err = busy_eff && ((wr_ctrl && wData[CTRL_START]) ||
                                (we && wr_cfg_hit));
`endif

  dmac_csr_status u_status (
    .clk_i      (clk),
    .reset_i    (reset),
    .done_i     (done_i),
    .clr_done_i (wr_status && wData[ST_DONE]),
`ifdef DMAC_CSR_ERR_EN
    .set_err_i  (set_err),
    .clr_err_i  (wr_status && wData[ST_ERR]),
`endif
    .ie_d_i     (ie_d),
    .done_o     (done_flag),
    .err_o      (err_flag),
    .irq_o      (irq_o)
  );

  // Read mux uses current register values, giving read-before-write.
  always_comb begin
    rdata_d = '0;
    if (rAddr == ADDR_W'(CSR_CTRL)) begin
      rdata_d[CTRL_IE] = ie_q;
    end else if (rAddr == ADDR_W'(CSR_STATUS)) begin
      rdata_d[ST_BUSY] = busy_i;
      rdata_d[ST_DONE] = done_flag;
      rdata_d[ST_ERR]  = err_flag;
    end else begin
      for (int unsigned i = 0; i < NCFG; i++) begin
        if (rAddr == ADDR_W'(i + CSR_CFG_BASE)) rdata_d = cfg_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q     <= 1'b0;
      start_q  <= 1'b0;
      cfg_q    <= '{default: '0};
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      ie_q     <= ie_d;
      start_q  <= start_d;
      cfg_q    <= cfg_d;
      rvalid_q <= re;
      if (re) rdata_q <= rdata_d;
    end
  end

  always_comb begin
    cfg_o = '0;
    for (int unsigned i = 0; i < NCFG; i++) begin
      cfg_o[i*DATA_W +: DATA_W] = cfg_q[i];
    end
  end

  assign rData   = rdata_q;
  assign rValid  = rvalid_q;
  assign start_o = start_q;

endmodule

// File: tb/tb_dmac_csr_file.sv
// tb_dmac_csr_file: directed self-checking bench for dmac_csr_file
// (DATA_W=8, ADDR_W=3, NUM_REGS=8). Expectations involving ERR follow
// DMAC_CSR_ERR_EN.
module tb_dmac_csr_file;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

`ifdef DMAC_CSR_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           we;
  logic [ADDR_W-1:0]              wAddr;
  logic [DATA_W-1:0]              wData;
  logic                           re;
  logic [ADDR_W-1:0]              rAddr;
  logic [DATA_W-1:0]              rData;
  logic                           rValid;
  logic                           start_o;
  logic                           busy_i;
  logic                           done_i;
  logic                           irq_o;
  logic [(NUM_REGS-2)*DATA_W-1:0] cfg_o;

  int errors = 0;
  int checks = 0;

  dmac_csr_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wAddr   (wAddr),
    .wData   (wData),
    .re      (re),
    .rAddr   (rAddr),
    .rData   (rData),
    .rValid  (rValid),
    .start_o (start_o),
    .busy_i  (busy_i),
    .done_i  (done_i),
    .irq_o   (irq_o),
    .cfg_o   (cfg_o)
  );

  always #5 clk = ~clk;

  // Advance one edge; sample and drive 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; wAddr = a; wData = d;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    re = 1'b1; rAddr = a;
    tick();
    re = 1'b0;
    chk({tag, ".valid"}, 32'(rValid), 32'd1);
    chk({tag, ".data"},  32'(rData),  32'(exp));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wAddr = '0; wData = '0;
    re = 1'b0; rAddr = '0; busy_i = 1'b0; done_i = 1'b0;
    tick(); tick();
    chk("rst.rData",  32'(rData),   32'd0);
    chk("rst.rValid", 32'(rValid),  32'd0);
    chk("rst.start",  32'(start_o), 32'd0);
    chk("rst.irq",    32'(irq_o),   32'd0);
    chk("rst.cfg",    32'(cfg_o[31:0]), 32'd0);
    reset = 1'b0;

    // All addresses read zero after reset
    for (int a = 0; a < 8; a++) do_read(ADDR_W'(a), 8'h00, $sformatf("rst.rd%0d", a));
    tick();
    chk("rvalid.fall", 32'(rValid), 32'd0);
    chk("rdata.hold",  32'(rData),  32'd0);

    // CFG write / readback
    do_write(3'd3, 8'hA5);
    chk("cfg3.out", 32'(cfg_o[15:8]), 32'hA5);
    chk("cfg2.out", 32'(cfg_o[7:0]),  32'h00);
    do_read(3'd3, 8'hA5, "cfg3.rd");

    // Read-before-write on the same address
    we = 1'b1; wAddr = 3'd4; wData = 8'h3C; re = 1'b1; rAddr = 3'd4;
    tick();
    we = 1'b0; re = 1'b0;
    chk("rbw.old", 32'(rData), 32'h00);
    do_read(3'd4, 8'h3C, "rbw.new");
    tick();
    chk("rdata.hold2", 32'(rData), 32'h3C);

    // START with IE, busy low: exactly one pulse
    do_write(3'd0, 8'h03);
    chk("start.pulse", 32'(start_o), 32'd1);
    tick();
    chk("start.end", 32'(start_o), 32'd0);
    do_read(3'd0, 8'h02, "ctrl.rd");

    // CFG write while busy is rejected
    busy_i = 1'b1;
    do_write(3'd2, 8'h11);
    chk("cfglock.out", 32'(cfg_o[7:0]), 32'h00);
    chk("cfglock.irq", 32'(irq_o), 32'(ERR_EN));
    do_read(3'd2, 8'h00, "cfglock.rd");
    do_read(3'd1, {5'b0, ERR_EN, 2'b01}, "cfglock.st");
    do_write(3'd1, 8'h04);
    chk("errclr.irq", 32'(irq_o), 32'd0);
    busy_i = 1'b0;
    do_read(3'd1, 8'h00, "errclr.st");

    // DONE with IE=1
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("done.irq", 32'(irq_o), 32'd1);
    do_read(3'd1, 8'h02, "done.st");
    // W1C collides with done_i: set wins
    we = 1'b1; wAddr = 3'd1; wData = 8'h02; done_i = 1'b1;
    tick();
    we = 1'b0; done_i = 1'b0;
    chk("setwins.irq", 32'(irq_o), 32'd1);
    do_read(3'd1, 8'h02, "setwins.st");
    do_write(3'd1, 8'h02);
    chk("doneclr.irq", 32'(irq_o), 32'd0);
    do_read(3'd1, 8'h00, "doneclr.st");

    // Back-to-back START: second one rejected by the pending pulse
    we = 1'b1; wAddr = 3'd0; wData = 8'h03;
    tick();
    chk("b2b.pulse1", 32'(start_o), 32'd1);
    tick();
    we = 1'b0;
    chk("b2b.nopulse", 32'(start_o), 32'd0);
    chk("b2b.irq", 32'(irq_o), 32'(ERR_EN));
    tick();
    chk("b2b.quiet", 32'(start_o), 32'd0);
    do_read(3'd1, {5'b0, ERR_EN, 2'b00}, "b2b.st");
    do_write(3'd1, 8'h04);

    // Reset mid-transfer with IE=1 and DONE=1
    busy_i = 1'b1;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk("pre.irq", 32'(irq_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.irq",   32'(irq_o),   32'd0);
    chk("midrst.start", 32'(start_o), 32'd0);
    chk("midrst.cfg",   32'(cfg_o[31:0]), 32'd0);
    do_read(3'd0, 8'h00, "midrst.ctrl");
    do_read(3'd3, 8'h00, "midrst.cfg3");
    do_read(3'd1, 8'h01, "midrst.busy");
    busy_i = 1'b0;
    do_read(3'd1, 8'h00, "midrst.idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
